// File: rtl/resource_pkg.sv
// Shared codes, state encoding and helpers for the resource transaction controller.
package resource_pkg;

    // Datapath width: every level is carried zero-extended to this width.
    localparam int LVL_W = 8;

    localparam logic [1:0] RES_ENERGY = 2'd0;
    localparam logic [1:0] RES_TRACER = 2'd1;
    localparam logic [1:0] RES_FLUID  = 2'd2;
    localparam logic [1:0] RES_NONE   = 2'd3;

    localparam logic OP_SPEND    = 1'b0;
    localparam logic OP_RECHARGE = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } txn_state_e;

    // All-ones value of a w-bit level, zero-extended to the datapath width.
    function automatic logic [LVL_W-1:0] max_level(input int w);
        max_level = LVL_W'((1 << w) - 1);
    endfunction

endpackage

// File: rtl/resource_txn_ctrl_if.sv
// Request/response handshake bundle between a requester and the controller.
interface resource_txn_ctrl_if;
    import resource_pkg::*;

    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_res;
    logic             req_op;
    logic [LVL_W-1:0] req_amt;

    logic             resp_valid;
    logic             resp_ready;
    logic             resp_ok;
    logic [LVL_W-1:0] resp_level;

    modport master (
        output req_valid, req_res, req_op, req_amt, resp_ready,
        input  req_ready, resp_valid, resp_ok, resp_level
    );

    modport slave (
        input  req_valid, req_res, req_op, req_amt, resp_ready,
        output req_ready, resp_valid, resp_ok, resp_level
    );

endinterface

// File: rtl/resource_alu.sv
// Combinational add/subtract for one resource level: borrow detect on spend,
// saturation at the resource's maximum on recharge.
module resource_alu
    import resource_pkg::*;
(
    input  logic [LVL_W-1:0] level_i,
    input  logic [LVL_W-1:0] amt_i,
    input  logic [LVL_W-1:0] max_i,
    input  logic             op_i,
    output logic [LVL_W-1:0] new_level_o,
    output logic             ok_o
);

    logic [LVL_W:0] lvl_x;
    logic [LVL_W:0] amt_x;
    logic [LVL_W:0] cin_x;
    logic [LVL_W:0] sum;
    logic           borrow;
    logic           over_max;

    // One 9-bit adder serves both ops; spend uses inverted amount plus carry-in.
    always_comb begin
        lvl_x    = {1'b0, level_i};
        amt_x    = (op_i == OP_RECHARGE) ? {1'b0, amt_i} : ~{1'b0, amt_i};
        cin_x    = {{LVL_W{1'b0}}, (op_i == OP_SPEND)};
        sum      = lvl_x + amt_x + cin_x;
        // A negative spend result shows up as the top bit of the 9-bit sum.
        borrow   = (op_i == OP_SPEND) && sum[LVL_W];
        over_max = (op_i == OP_RECHARGE) && (sum > {1'b0, max_i});

        ok_o = !borrow;
        if (borrow) begin
            new_level_o = level_i;
        end else if (over_max) begin
            new_level_o = max_i;
        end else begin
            new_level_o = sum[LVL_W-1:0];
        end
    end

endmodule

// File: rtl/resource_txn_ctrl.sv
// Transaction front-end for the resource levels: one spend/recharge at a time,
// level write-back, then a grant/deny response.
//
//   state | meaning
//   IDLE  | req_ready high, waiting for a request
//   CALC  | ALU evaluates latched request, result and grant registered
//   WRITE | granted result loaded into the selected level register
//   RESP  | response presented until resp_ready
module resource_txn_ctrl
    import resource_pkg::*;
#(
    parameter int             E_W    = 8,
    parameter int             T_W    = 6,
    parameter int             F_W    = 4,
    parameter logic [E_W-1:0] E_INIT = 8'hFF,
    parameter logic [T_W-1:0] T_INIT = 6'h3F,
    parameter logic [F_W-1:0] F_INIT = 4'hF
)(
    input  logic                clk,
    input  logic                rst,
    resource_txn_ctrl_if.slave  bus,
    output logic [E_W-1:0]      energy,
    output logic [T_W-1:0]      tracer,
    output logic [F_W-1:0]      fluid
);

    localparam logic [LVL_W-1:0] E_MAX = max_level(E_W);
    localparam logic [LVL_W-1:0] T_MAX = max_level(T_W);
    localparam logic [LVL_W-1:0] F_MAX = max_level(F_W);

    txn_state_e       state_q, state_d;

    logic [1:0]       res_q;
    logic             op_q;
    logic [LVL_W-1:0] amt_q;
    logic [LVL_W-1:0] result_q, result_d;
    logic             ok_q, ok_d;

    logic [E_W-1:0]   energy_q;
    logic [T_W-1:0]   tracer_q;
    logic [F_W-1:0]   fluid_q;

    logic             accept;
    logic [LVL_W-1:0] cur_level;
    logic [LVL_W-1:0] cur_max;
    logic [LVL_W-1:0] alu_level;
    logic             alu_ok;

    assign accept = (state_q == IDLE) && bus.req_valid;

    // Select the addressed level and its ceiling for the ALU.
    always_comb begin
        cur_level = '0;
        cur_max   = '0;
        case (res_q)
            RES_ENERGY: begin
                cur_level = LVL_W'(energy_q);
                cur_max   = E_MAX;
            end
            RES_TRACER: begin
                cur_level = LVL_W'(tracer_q);
                cur_max   = T_MAX;
            end
            RES_FLUID: begin
                cur_level = LVL_W'(fluid_q);
                cur_max   = F_MAX;
            end
            default: begin
                cur_level = '0;
                cur_max   = '0;
            end
        endcase
    end

    resource_alu u_alu (
        .level_i     (cur_level),
        .amt_i       (amt_q),
        .max_i       (cur_max),
        .op_i        (op_q),
        .new_level_o (alu_level),
        .ok_o        (alu_ok)
    );

    // An invalid resource code is always denied with a zero level.
    always_comb begin
        result_d = alu_level;
        ok_d     = alu_ok;
        if (res_q == RES_NONE) begin
            result_d = '0;
            ok_d     = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = CALC;
            CALC:    state_d = WRITE;
            WRITE:   state_d = RESP;
            RESP:    if (bus.resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake and response outputs; response fields read zero outside RESP.
    always_comb begin
        bus.req_ready  = (state_q == IDLE);
        bus.resp_valid = (state_q == RESP);
        bus.resp_ok    = (state_q == RESP) && ok_q;
        bus.resp_level = (state_q == RESP) ? result_q : '0;
    end

    // Request capture and registered ALU result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_q    <= RES_ENERGY;
            op_q     <= OP_SPEND;
            amt_q    <= '0;
            result_q <= '0;
            ok_q     <= 1'b0;
        end else begin
            if (accept) begin
                res_q <= bus.req_res;
                op_q  <= bus.req_op;
                amt_q <= bus.req_amt;
            end
            if (state_q == CALC) begin
                result_q <= result_d;
                ok_q     <= ok_d;
            end
        end
    end

    // Level registers, loaded only in WRITE and only for a granted request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            energy_q <= E_INIT;
            tracer_q <= T_INIT;
            fluid_q  <= F_INIT;
        end else if ((state_q == WRITE) && ok_q) begin
            if (res_q == RES_ENERGY) energy_q <= result_q[E_W-1:0];
            if (res_q == RES_TRACER) tracer_q <= result_q[T_W-1:0];
            if (res_q == RES_FLUID)  fluid_q  <= result_q[F_W-1:0];
        end
    end

    assign energy = energy_q;
    assign tracer = tracer_q;
    assign fluid  = fluid_q;

endmodule

// File: tb/tb_resource_txn_ctrl.sv
// Bench for resource_txn_ctrl: directed scenarios plus randomized traffic
// compared against an arithmetic model of the resource levels.
module tb_resource_txn_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] energy;
    logic [5:0] tracer;
    logic [3:0] fluid;

    resource_txn_ctrl_if bus();

    resource_txn_ctrl dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .energy (energy),
        .tracer (tracer),
        .fluid  (fluid)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int mdl_lvl [3];
    int mdl_max [3] = '{255, 63, 15};

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mdl_lvl = '{255, 63, 15};
    endtask

    task automatic model_txn(input int res, input int op, input int amt,
                             output int ok, output int lvl);
        if (res == 3) begin
            ok  = 0;
            lvl = 0;
        end else if (op == 0) begin
            if (amt <= mdl_lvl[res]) begin
                mdl_lvl[res] = mdl_lvl[res] - amt;
                ok = 1;
            end else begin
                ok = 0;
            end
            lvl = mdl_lvl[res];
        end else begin
            mdl_lvl[res] = (mdl_lvl[res] + amt > mdl_max[res]) ? mdl_max[res]
                                                                : mdl_lvl[res] + amt;
            ok  = 1;
            lvl = mdl_lvl[res];
        end
    endtask

    task automatic chk_levels(input string tag);
        chk({tag, ".energy"}, int'(energy), mdl_lvl[0]);
        chk({tag, ".tracer"}, int'(tracer), mdl_lvl[1]);
        chk({tag, ".fluid"},  int'(fluid),  mdl_lvl[2]);
    endtask

    // One full transaction; bp = cycles of resp_ready low. While busy a junk
    // request is held on the bus, which the controller must ignore.
    task automatic txn(input int res, input int op, input int amt, input int bp);
        int lat;
        int eok;
        int elvl;
        @(negedge clk);
        chk("idle_ready", int'(bus.req_ready), 1);
        bus.req_valid = 1'b1;
        bus.req_res   = res[1:0];
        bus.req_op    = op[0];
        bus.req_amt   = amt[7:0];
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = (bp > 0);
        bus.req_res   = 2'd0;
        bus.req_op    = 1'b0;
        bus.req_amt   = 8'd1;
        chk("busy_ready", int'(bus.req_ready), 0);
        lat = 1;
        while (!bus.resp_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, 3);
        model_txn(res, op, amt, eok, elvl);
        chk("resp_ok", int'(bus.resp_ok), eok);
        chk("resp_level", int'(bus.resp_level), elvl);
        chk_levels("resp");
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            chk("bp_valid", int'(bus.resp_valid), 1);
            chk("bp_ok", int'(bus.resp_ok), eok);
            chk("bp_level", int'(bus.resp_level), elvl);
            chk("bp_req_ready", int'(bus.req_ready), 0);
        end
        bus.resp_ready = 1'b1;
        bus.req_valid  = 1'b0;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        chk("post_valid", int'(bus.resp_valid), 0);
        chk("post_ready", int'(bus.req_ready), 1);
        chk_levels("post");
    endtask

    initial begin
        rst            = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_res    = 2'd0;
        bus.req_op     = 1'b0;
        bus.req_amt    = 8'd0;
        bus.resp_ready = 1'b0;
        model_reset();

        repeat (2) @(negedge clk);
        chk_levels("rst");
        chk("rst_req_ready", int'(bus.req_ready), 1);
        chk("rst_resp_valid", int'(bus.resp_valid), 0);
        chk("rst_resp_ok", int'(bus.resp_ok), 0);
        chk("rst_resp_level", int'(bus.resp_level), 0);
        rst = 1'b0;
        @(negedge clk);
        chk_levels("rel");

        txn(0, 0, 100, 0);
        txn(2, 0, 20, 0);
        txn(1, 0, 60, 0);
        txn(1, 1, 200, 0);
        txn(0, 0, 0, 0);
        txn(0, 1, 10, 5);

        // Reset while the energy spend is in CALC.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_res   = 2'd0;
        bus.req_op    = 1'b0;
        bus.req_amt   = 8'd50;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        rst = 1'b1;
        #1;
        model_reset();
        chk_levels("mid_rst");
        chk("mid_rst_valid", int'(bus.resp_valid), 0);
        chk("mid_rst_ready", int'(bus.req_ready), 1);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("mid_rst_noresp", int'(bus.resp_valid), 0);
            chk("mid_rst_energy", int'(energy), 255);
        end

        txn(3, 0, 5, 0);

        for (int n = 0; n < 60; n++) begin
            int r;
            int o;
            int a;
            int b;
            r = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
            o = int'($urandom_range(0, 1));
            a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                            : int'($urandom_range(0, 40));
            b = int'($urandom_range(0, 3));
            txn(r, o, a, b);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
